// File: rtl/fft_frame_collector.sv
// Collects one complex FFT frame per start/over burst into a ping-pong buffer and replays it in order.
// Define COLLECT_BITREV_EN to write at bit-reversed addresses so the output comes out in natural order.
module fft_frame_collector #(
  parameter int LAYER = 4,
  parameter int DW    = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic signed [DW-1:0] in_real,
  input  logic signed [DW-1:0] in_img,
  input  logic                 start,
  input  logic                 over,
  output logic signed [DW-1:0] out_real,
  output logic signed [DW-1:0] out_img,
  output logic                 out_valid,
  output logic                 out_start,
  output logic                 out_end,
  output logic                 err
);
  localparam int N = 1 << LAYER;
  localparam logic [LAYER-1:0] LAST = LAYER'(N - 1);

  typedef enum logic {IDLE, FILL} state_t;
  state_t state, state_n;

  logic [LAYER-1:0] wi, wi_n, idx, waddr;
  logic             wbank, wbank_n, err_n, done, we, last;

  logic [2*DW-1:0]  mem [0:2*N-1];

  logic [LAYER-1:0] ra;
  logic             rd_act, rd_bank;
  logic [2*DW-1:0]  rd_p0;
  logic             vld_p0, first_p0, last_p0;

`ifdef COLLECT_BITREV_EN
  function automatic logic [LAYER-1:0] bitrev(input logic [LAYER-1:0] a);
    logic [LAYER-1:0] r;
    for (int i = 0; i < LAYER; i++) r[i] = a[LAYER-1-i];
    return r;
  endfunction
`endif

  // A start pulse always (re)starts the frame at index 0, even mid-fill.
  assign we   = start || (state == FILL);
  assign idx  = start ? '0 : wi;
  assign last = (idx == LAST);

`ifdef COLLECT_BITREV_EN
  assign waddr = bitrev(idx);
`else
  assign waddr = idx;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      wi    <= '0;
      wbank <= 1'b0;
      err   <= 1'b0;
    end else begin
      state <= state_n;
      wi    <= wi_n;
      wbank <= wbank_n;
      err   <= err_n;
    end
  end

  always_comb begin
    state_n = state;
    wi_n    = wi;
    wbank_n = wbank;
    err_n   = 1'b0;
    done    = 1'b0;
    if (we) begin
      err_n = (state == FILL) && start;
      if (over) begin
        state_n = IDLE;
        wi_n    = '0;
        if (last) begin
          done    = 1'b1;
          wbank_n = ~wbank;
        end else begin
          err_n = 1'b1;
        end
      end else if (last) begin
        // Frame filled without its closing over pulse: discard.
        state_n = IDLE;
        wi_n    = '0;
        err_n   = 1'b1;
      end else begin
        state_n = FILL;
        wi_n    = idx + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (we) mem[{wbank, waddr}] <= {in_real, in_img};
  end

  // Read sequencer: a completed frame restarts the scan on the bank just filled.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_act  <= 1'b0;
      ra      <= '0;
      rd_bank <= 1'b0;
    end else if (done) begin
      rd_act  <= 1'b1;
      ra      <= '0;
      rd_bank <= wbank;
    end else if (rd_act) begin
      ra <= ra + 1'b1;
      if (ra == LAST) rd_act <= 1'b0;
    end
  end

  // Stage p0: synchronous RAM read
  always_ff @(posedge clk) begin
    rd_p0 <= mem[{rd_bank, ra}];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_p0   <= 1'b0;
      first_p0 <= 1'b0;
      last_p0  <= 1'b0;
    end else begin
      vld_p0   <= rd_act;
      first_p0 <= rd_act && (ra == '0);
      last_p0  <= rd_act && (ra == LAST);
    end
  end

  // Output stage: data forced to zero outside valid cycles
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_real  <= '0;
      out_img   <= '0;
      out_valid <= 1'b0;
      out_start <= 1'b0;
      out_end   <= 1'b0;
    end else begin
      out_real  <= vld_p0 ? $signed(rd_p0[2*DW-1:DW]) : '0;
      out_img   <= vld_p0 ? $signed(rd_p0[DW-1:0]) : '0;
      out_valid <= vld_p0;
      out_start <= first_p0;
      out_end   <= last_p0;
    end
  end

endmodule

// File: tb/tb_fft_frame_collector.sv
// Directed bench for fft_frame_collector: ordering, latency, back-to-back, malformed frames, reset.
module tb_fft_frame_collector;
  localparam int LAYER = 4;
  localparam int DW    = 32;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic signed [DW-1:0] in_real = '0;
  logic signed [DW-1:0] in_img = '0;
  logic                 start = 1'b0;
  logic                 over = 1'b0;
  logic signed [DW-1:0] out_real, out_img;
  logic                 out_valid, out_start, out_end, err;

  always #5 clk = ~clk;

  fft_frame_collector #(.LAYER(LAYER), .DW(DW)) dut (
    .clk(clk), .rst(rst), .in_real(in_real), .in_img(in_img),
    .start(start), .over(over), .out_real(out_real), .out_img(out_img),
    .out_valid(out_valid), .out_start(out_start), .out_end(out_end), .err(err)
  );

  int asserts = 0, fails = 0;
  int ncyc = 0, n_err = 0, err_cyc = -1, first_vld = -1;
  int run = 0, max_run = 0, zero_bad = 0, n_start = 0, n_end = 0;
  int cap_re[$], cap_im[$];
  bit cap_st[$], cap_en[$];

  initial forever begin
    @(negedge clk);
    ncyc++;
    if (err) begin
      n_err++;
      err_cyc = ncyc;
    end
    if (out_valid) begin
      if (first_vld < 0) first_vld = ncyc;
      cap_re.push_back(int'(out_real));
      cap_im.push_back(int'(out_img));
      cap_st.push_back(out_start);
      cap_en.push_back(out_end);
      if (out_start) n_start++;
      if (out_end) n_end++;
      run++;
      if (run > max_run) max_run = run;
    end else begin
      run = 0;
      if (out_real != 0 || out_img != 0 || out_start || out_end) zero_bad++;
    end
  end

  function automatic int exp_idx(input int k);
`ifdef COLLECT_BITREV_EN
    int r = 0;
    for (int b = 0; b < 4; b++) if (k[b]) r |= (1 << (3 - b));
    return r;
`else
    return k;
`endif
  endfunction

  task automatic clear_mon();
    cap_re.delete(); cap_im.delete(); cap_st.delete(); cap_en.delete();
    n_err = 0; err_cyc = -1; first_vld = -1;
    run = 0; max_run = 0; zero_bad = 0; n_start = 0; n_end = 0;
  endtask

  task automatic drive(input int re, input int im, input bit st, input bit ov);
    in_real = re; in_img = im; start = st; over = ov;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    in_real = 0; in_img = 0; start = 0; over = 0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input int base, input int len, input bit with_over, output int last_ncyc);
    for (int i = 0; i < len; i++)
      drive(base + i, -(base + i), i == 0, with_over && (i == len - 1));
    last_ncyc = ncyc;
    in_real = 0; in_img = 0; start = 0; over = 0;
  endtask

  task automatic test_reset();
    #1 rst = 1'b0;
    #1;
    asserts++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    asserts++; if (out_real !== '0) begin fails++; $display("FAIL reset_real: got %0d want 0", out_real); end
    asserts++; if (out_img !== '0) begin fails++; $display("FAIL reset_img: got %0d want 0", out_img); end
    asserts++; if ({out_start, out_end, err} !== 3'b000) begin fails++; $display("FAIL reset_flags: got %b want 000", {out_start, out_end, err}); end
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    idle(2);
  endtask

  task automatic test_bitrev();
    int oc;
    clear_mon();
    send_frame(0, 16, 1'b1, oc);
    idle(24);
    asserts++; if (cap_re.size() !== 16) begin fails++; $display("FAIL bitrev_count: got %0d want 16", cap_re.size()); end
    asserts++; if (first_vld !== oc + 3) begin fails++; $display("FAIL bitrev_latency: got %0d want %0d", first_vld, oc + 3); end
    for (int k = 0; k < 16 && k < cap_re.size(); k++) begin
      asserts++; if (cap_re[k] !== exp_idx(k)) begin fails++; $display("FAIL bitrev_re[%0d]: got %0d want %0d", k, cap_re[k], exp_idx(k)); end
      asserts++; if (cap_im[k] !== -exp_idx(k)) begin fails++; $display("FAIL bitrev_im[%0d]: got %0d want %0d", k, cap_im[k], -exp_idx(k)); end
      asserts++; if (cap_st[k] !== (k == 0)) begin fails++; $display("FAIL bitrev_start[%0d]: got %b want %b", k, cap_st[k], k == 0); end
      asserts++; if (cap_en[k] !== (k == 15)) begin fails++; $display("FAIL bitrev_end[%0d]: got %b want %b", k, cap_en[k], k == 15); end
    end
    asserts++; if (n_err !== 0) begin fails++; $display("FAIL bitrev_err: got %0d want 0", n_err); end
    asserts++; if (max_run !== 16) begin fails++; $display("FAIL bitrev_run: got %0d want 16", max_run); end
    asserts++; if (zero_bad !== 0) begin fails++; $display("FAIL bitrev_idle_zero: got %0d want 0", zero_bad); end
  endtask

  task automatic test_back_to_back();
    int oc;
    clear_mon();
    for (int f = 1; f <= 3; f++) send_frame(100 * f, 16, 1'b1, oc);
    idle(24);
    asserts++; if (cap_re.size() !== 48) begin fails++; $display("FAIL b2b_count: got %0d want 48", cap_re.size()); end
    asserts++; if (max_run !== 48) begin fails++; $display("FAIL b2b_contiguous: got %0d want 48", max_run); end
    asserts++; if (n_start !== 3) begin fails++; $display("FAIL b2b_starts: got %0d want 3", n_start); end
    asserts++; if (n_end !== 3) begin fails++; $display("FAIL b2b_ends: got %0d want 3", n_end); end
    asserts++; if (n_err !== 0) begin fails++; $display("FAIL b2b_err: got %0d want 0", n_err); end
    for (int j = 0; j < 48 && j < cap_re.size(); j++) begin
      asserts++;
      if (cap_re[j] !== 100 * (j / 16 + 1) + exp_idx(j % 16)) begin
        fails++; $display("FAIL b2b_re[%0d]: got %0d want %0d", j, cap_re[j], 100 * (j / 16 + 1) + exp_idx(j % 16));
      end
    end
  endtask

  task automatic test_short();
    int oc;
    clear_mon();
    send_frame(40, 10, 1'b1, oc);
    idle(24);
    asserts++; if (n_err !== 1) begin fails++; $display("FAIL short_err_count: got %0d want 1", n_err); end
    asserts++; if (err_cyc !== oc + 1) begin fails++; $display("FAIL short_err_time: got %0d want %0d", err_cyc, oc + 1); end
    asserts++; if (cap_re.size() !== 0) begin fails++; $display("FAIL short_no_output: got %0d want 0", cap_re.size()); end
    clear_mon();
    drive(7, -7, 1'b1, 1'b1);
    oc = ncyc;
    idle(24);
    asserts++; if (n_err !== 1) begin fails++; $display("FAIL single_err_count: got %0d want 1", n_err); end
    asserts++; if (err_cyc !== oc + 1) begin fails++; $display("FAIL single_err_time: got %0d want %0d", err_cyc, oc + 1); end
    asserts++; if (cap_re.size() !== 0) begin fails++; $display("FAIL single_no_output: got %0d want 0", cap_re.size()); end
    clear_mon();
    send_frame(60, 16, 1'b1, oc);
    idle(24);
    asserts++; if (cap_re.size() !== 16) begin fails++; $display("FAIL short_next_count: got %0d want 16", cap_re.size()); end
    asserts++; if (n_err !== 0) begin fails++; $display("FAIL short_next_err: got %0d want 0", n_err); end
    for (int k = 0; k < 16 && k < cap_re.size(); k++) begin
      asserts++; if (cap_re[k] !== 60 + exp_idx(k)) begin fails++; $display("FAIL short_next_re[%0d]: got %0d want %0d", k, cap_re[k], 60 + exp_idx(k)); end
    end
  endtask

  task automatic test_overrun();
    int oc;
    clear_mon();
    send_frame(80, 16, 1'b0, oc);
    idle(24);
    asserts++; if (n_err !== 1) begin fails++; $display("FAIL overrun_err_count: got %0d want 1", n_err); end
    asserts++; if (err_cyc !== oc + 1) begin fails++; $display("FAIL overrun_err_time: got %0d want %0d", err_cyc, oc + 1); end
    asserts++; if (cap_re.size() !== 0) begin fails++; $display("FAIL overrun_no_output: got %0d want 0", cap_re.size()); end
  endtask

  task automatic test_restart();
    int oc, oc2;
    clear_mon();
    send_frame(500, 5, 1'b0, oc);
    send_frame(600, 16, 1'b1, oc2);
    idle(24);
    asserts++; if (n_err !== 1) begin fails++; $display("FAIL restart_err_count: got %0d want 1", n_err); end
    asserts++; if (err_cyc !== oc2 - 14) begin fails++; $display("FAIL restart_err_time: got %0d want %0d", err_cyc, oc2 - 14); end
    asserts++; if (cap_re.size() !== 16) begin fails++; $display("FAIL restart_count: got %0d want 16", cap_re.size()); end
    asserts++; if (first_vld !== oc2 + 3) begin fails++; $display("FAIL restart_latency: got %0d want %0d", first_vld, oc2 + 3); end
    for (int k = 0; k < 16 && k < cap_re.size(); k++) begin
      asserts++; if (cap_re[k] !== 600 + exp_idx(k)) begin fails++; $display("FAIL restart_re[%0d]: got %0d want %0d", k, cap_re[k], 600 + exp_idx(k)); end
    end
  endtask

  task automatic test_reset_mid();
    int oc;
    clear_mon();
    send_frame(700, 16, 1'b1, oc);
    for (int t = 0; t < 100 && cap_re.size() < 8; t++) begin
      @(negedge clk); #1;
    end
    asserts++; if (cap_re.size() !== 8) begin fails++; $display("FAIL rstmid_reach7: got %0d samples want 8", cap_re.size()); end
    rst = 1'b0;
    #1;
    asserts++; if (out_valid !== 1'b0) begin fails++; $display("FAIL rstmid_valid: got %b want 0", out_valid); end
    asserts++; if (out_real !== '0 || out_img !== '0) begin fails++; $display("FAIL rstmid_data: got %0d/%0d want 0/0", out_real, out_img); end
    asserts++; if ({out_start, out_end, err} !== 3'b000) begin fails++; $display("FAIL rstmid_flags: got %b want 000", {out_start, out_end, err}); end
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    idle(30);
    asserts++; if (cap_re.size() !== 8) begin fails++; $display("FAIL rstmid_no_more: got %0d samples want 8", cap_re.size()); end
    asserts++; if (n_err !== 0) begin fails++; $display("FAIL rstmid_err: got %0d want 0", n_err); end
    asserts++; if (zero_bad !== 0) begin fails++; $display("FAIL rstmid_idle_zero: got %0d want 0", zero_bad); end
  endtask

  initial begin
    test_reset();
    test_bitrev();
    test_back_to_back();
    test_short();
    test_overrun();
    test_restart();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end

endmodule
